boss_ctrl: RTL

Sequencing controller for the stage-3 boss sprite. It generates the `boss_x`, `boss_y` and `boss_state` values consumed by the boss renderer. It owns boss patrol movement, walk animation, hit/hurt handling, hit points and the death sequence. It also free-runs a walk animation outside STAGE3, so the FAIL and STAFF screens show an animated boss at their fixed positions.

---
 rtl/boss_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/boss_ctrl.sv
// rtl/boss_ctrl.sv - stage-3 boss sprite sequencer: patrol, walk animation, hurt window, hit points, death sequence
module boss_ctrl #(
    parameter int STAGE3     = 6,
    parameter int X_INIT     = 150,
    parameter int Y_INIT     = 40,
    parameter int X_MIN      = 20,
    parameter int X_MAX      = 290,
    parameter int SPEED      = 1,
    parameter int MOVE_DIV   = 1,
    parameter int ANIM_DIV   = 8,
    parameter int HP_INIT    = 5,
    parameter int HURT_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       tick,
    input  logic       hit,
    output logic [8:0] boss_x,
    output logic [8:0] boss_y,
    output logic [3:0] boss_state,
    output logic [3:0] boss_hp,
    output logic       boss_defeated
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PATROL = 3'd1;
    localparam logic [2:0] S_HURT   = 3'd2;
    localparam logic [2:0] S_DYING  = 3'd3;
    localparam logic [2:0] S_DEAD   = 3'd4;

    localparam logic [8:0] X_INIT9    = 9'(X_INIT);
    localparam logic [8:0] Y_INIT9    = 9'(Y_INIT);
    localparam logic [8:0] X_MIN9     = 9'(X_MIN);
    localparam logic [8:0] X_MAX9     = 9'(X_MAX);
    localparam logic [8:0] SPEED9     = 9'(SPEED);
    localparam logic [9:0] X_MAX10    = 10'(X_MAX);
    localparam logic [9:0] X_LO_TEST  = 10'(X_MIN + SPEED);
    localparam logic [9:0] SPEED10    = 10'(SPEED);
    localparam logic [3:0] HP_INIT4   = 4'(HP_INIT);
    localparam logic [7:0] ANIM_LAST  = 8'(ANIM_DIV - 1);
    localparam logic [7:0] MOVE_LAST  = 8'(MOVE_DIV - 1);
    localparam logic [7:0] HURT_LAST  = 8'(HURT_TICKS - 1);

    logic [2:0] fsm, fsm_n;
    logic       dir, dir_n;          // 1 = moving left
    logic [7:0] anim_cnt, anim_cnt_n;
    logic [1:0] anim_idx, anim_idx_n;
    logic [7:0] move_cnt, move_cnt_n;
    logic [7:0] hurt_cnt, hurt_cnt_n;
    logic [1:0] die_idx, die_idx_n;
    logic [8:0] x_n;
    logic [3:0] hp_n;
    logic [3:0] frame_n;

    logic       in_stage;
    logic       anim_wrap, move_wrap;
    logic [7:0] anim_step, move_step;
    logic [9:0] x_ext, x_right;

    assign in_stage  = (state == 4'(STAGE3));
    assign anim_wrap = (anim_cnt == ANIM_LAST);
    assign move_wrap = (move_cnt == MOVE_LAST);
    assign anim_step = anim_wrap ? 8'd0 : anim_cnt + 8'd1;
    assign move_step = move_wrap ? 8'd0 : move_cnt + 8'd1;
    assign x_ext     = {1'b0, boss_x};
    assign x_right   = x_ext + SPEED10;

    always_comb begin
        fsm_n      = fsm;
        dir_n      = dir;
        anim_cnt_n = anim_cnt;
        anim_idx_n = anim_idx;
        move_cnt_n = move_cnt;
        hurt_cnt_n = hurt_cnt;
        die_idx_n  = die_idx;
        x_n        = boss_x;
        hp_n       = boss_hp;

        // Leaving STAGE3 from any active state, or entering it from IDLE, restarts from init
        if ((fsm != S_IDLE && !in_stage) || (fsm == S_IDLE && in_stage)) begin
            fsm_n      = in_stage ? S_PATROL : S_IDLE;
            dir_n      = 1'b0;
            anim_cnt_n = 8'd0;
            anim_idx_n = 2'd0;
            move_cnt_n = 8'd0;
            hurt_cnt_n = 8'd0;
            die_idx_n  = 2'd0;
            x_n        = X_INIT9;
            hp_n       = HP_INIT4;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (tick) begin
                        anim_cnt_n = anim_step;
                        if (anim_wrap) anim_idx_n = anim_idx + 2'd1;
                    end
                end
                S_PATROL: begin
                    if (hit) begin
                        hp_n = boss_hp - 4'd1;
                        if (boss_hp == 4'd1) begin
                            fsm_n      = S_DYING;
                            die_idx_n  = 2'd0;
                            anim_cnt_n = 8'd0;
                        end else begin
                            fsm_n      = S_HURT;
                            hurt_cnt_n = 8'd0;
                        end
                    end else if (tick) begin
                        anim_cnt_n = anim_step;
                        if (anim_wrap) anim_idx_n = anim_idx + 2'd1;
                        move_cnt_n = move_step;
                        if (move_wrap) begin
                            if (!dir) begin
                                if (x_right >= X_MAX10) begin
                                    x_n   = X_MAX9;
                                    dir_n = 1'b1;
                                end else begin
                                    x_n = x_right[8:0];
                                end
                            end else begin
                                if (x_ext <= X_LO_TEST) begin
                                    x_n   = X_MIN9;
                                    dir_n = 1'b0;
                                end else begin
                                    x_n = boss_x - SPEED9;
                                end
                            end
                        end
                    end
                end
                S_HURT: begin
                    // The exit tick is spent on leaving HURT, not on a move
                    if (tick) begin
                        if (hurt_cnt == HURT_LAST) fsm_n = S_PATROL;
                        else                       hurt_cnt_n = hurt_cnt + 8'd1;
                    end
                end
                S_DYING: begin
                    if (tick) begin
                        anim_cnt_n = anim_step;
                        if (anim_wrap) begin
                            if (die_idx == 2'd2) fsm_n = S_DEAD;
                            else                 die_idx_n = die_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (fsm_n)
            S_IDLE:   frame_n = {2'b00, anim_idx_n};
            S_PATROL: frame_n = {1'b0, dir_n, anim_idx_n};
            S_HURT:   frame_n = 4'd8;
            S_DYING:  frame_n = 4'd9 + {2'b00, die_idx_n};
            default:  frame_n = 4'd12;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm           <= S_IDLE;
            dir           <= 1'b0;
            anim_cnt      <= 8'd0;
            anim_idx      <= 2'd0;
            move_cnt      <= 8'd0;
            hurt_cnt      <= 8'd0;
            die_idx       <= 2'd0;
            boss_x        <= X_INIT9;
            boss_y        <= Y_INIT9;
            boss_state    <= 4'd0;
            boss_hp       <= HP_INIT4;
            boss_defeated <= 1'b0;
        end else begin
            fsm           <= fsm_n;
            dir           <= dir_n;
            anim_cnt      <= anim_cnt_n;
            anim_idx      <= anim_idx_n;
            move_cnt      <= move_cnt_n;
            hurt_cnt      <= hurt_cnt_n;
            die_idx       <= die_idx_n;
            boss_x        <= x_n;
            boss_y        <= Y_INIT9;
            boss_state    <= frame_n;
            boss_hp       <= hp_n;
            boss_defeated <= (fsm_n == S_DEAD);
        end
    end

endmodule
